// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_W               = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Character output bus of uart_rx toward the hex loader.
// The parity error strobe exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;

  logic [7:0] o_rx_data;
  logic       o_rx_stb;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;

  modport master (output o_rx_data, o_rx_stb, o_frame_err, o_parity_err);
  modport slave  (input  o_rx_data, o_rx_stb, o_frame_err, o_parity_err);
`else
  modport master (output o_rx_data, o_rx_stb, o_frame_err);
  modport slave  (input  o_rx_data, o_rx_stb, o_frame_err);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even parity bit and the parity error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_rx,
  uart_rx_if.master rx_bus
);

  localparam int DATA_W = UART_DATA_W;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                rx_s;
  uart_rx_state_t      state_q,  state_d;
  logic [CNT_W-1:0]    baud_cnt, baud_cnt_d;
  logic [2:0]          bit_idx,  bit_idx_d;
  logic [DATA_W-1:0]   shift_q,  shift_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic                stb_q,    stb_d;
  logic                ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                par_q,    par_d;
  logic                perr_q,   perr_d;

  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~^{d, p};
  endfunction
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    data_d     = data_q;
    stb_d      = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[DATA_W-1:1]};
          bit_idx_d  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_d = '0;
          par_d      = rx_s;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (!parity_ok(shift_q, par_q)) begin
            perr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            data_d  = shift_q;
            stb_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        // A held-low line must report once, not be parsed as a stream of zero bytes.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign rx_bus.o_rx_data   = data_q;
  assign rx_bus.o_rx_stb    = stb_q;
  assign rx_bus.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated from the line protocol and
// each expected outcome (strobe, framing or parity error, and its cycle) is queued.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Line driven low after cycle N: synchronizer makes T0 = edge N+3; the stop
  // bit is sampled at T0 + C/2 + (NBITS-1)*C and the pulse is seen in that cycle.
  localparam int LAT = 3 + C / 2 + (NBITS - 1) * C;

  typedef enum logic [2:0] {K_STB = 3'b100, K_FERR = 3'b010, K_PERR = 3'b001} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic i_reset;
  logic i_rx;
  logic perr;
  int   cyc;
  int   vectors;
  int   errors;
  logic [7:0] last_data;
  exp_t exp_q[$];

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_rx    (i_rx),
    .rx_bus  (bus)
  );

`ifdef UART_RX_PARITY_EN
  assign perr = bus.o_parity_err;
`else
  assign perr = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    vectors   = 0;
    errors    = 0;
    last_data = 8'h00;
  end

  // Monitor: reset values while reset is high, otherwise pop and compare each event.
  always @(negedge clk) begin
    logic [2:0] ev;
    logic [7:0] want_data;
    exp_t e;
    if (i_reset) begin
      vectors++;
      last_data = 8'h00;
      if (bus.o_rx_data !== 8'h00 || bus.o_rx_stb !== 1'b0 || bus.o_frame_err !== 1'b0 || perr !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals: data=%h stb=%b ferr=%b perr=%b, required 00 0 0 0",
                 bus.o_rx_data, bus.o_rx_stb, bus.o_frame_err, perr);
      end
    end else begin
      ev = {bus.o_rx_stb, bus.o_frame_err, perr};
      if (ev != 3'b000) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: stb/ferr/perr=%b data=%h at cycle %0d, required nothing",
                   ev, bus.o_rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          want_data = (e.kind == K_STB) ? e.data : last_data;
          if (ev !== e.kind || bus.o_rx_data !== want_data || cyc != e.cyc) begin
            errors++;
            $display("FAIL event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                     ev, bus.o_rx_data, cyc, e.kind, want_data, e.cyc);
          end
          if (e.kind == K_STB) last_data = e.data;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        vectors++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_event: nothing by cycle %0d, required kind=%b data=%h at cycle %0d",
                 cyc, e.kind, e.data, e.cyc);
      end
    end
  end

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + LAT;
    if (!stop_ok) e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
    else if (!par_ok) e.kind = K_PERR;
`endif
    else e.kind = K_STB;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^d : ~^d);
`endif
    drive_bit(stop_ok);
  endtask

  task automatic glitch(input int len);
    i_rx = 1'b0;
    repeat (len) @(negedge clk);
    i_rx = 1'b1;
  endtask

  initial begin
    int r;
    i_rx    = 1'b1;
    i_reset = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 i_reset = 1'b0;
    @(negedge clk);
    idle(2 * C);

    send_frame(8'h3A, 1'b1, 1'b1);
    idle(C);
    send_frame(8'h30, 1'b1, 1'b1);
    send_frame(8'h31, 1'b1, 1'b1);
    idle(C);

    glitch(5);
    idle(2 * C);

    send_frame(8'h55, 1'b0, 1'b1);
    i_rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * C);
    send_frame(8'h41, 1'b1, 1'b1);
    idle(C);

    // Abort 8'hFF during bit 4 with reset; the rest of the frame is high anyway.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (C / 2) @(negedge clk);
    @(posedge clk);
    #2 i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 i_reset = 1'b0;
    @(negedge clk);
    idle(5 * C);
    send_frame(8'h0D, 1'b1, 1'b1);
    idle(C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(C);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(C);
`endif

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 6)));
        idle(C);
      end else begin
        send_frame(8'($urandom), r != 1, r != 2);
        if (r == 1) begin
          i_rx = 1'b0;
          repeat (int'($urandom_range(0, 30))) @(negedge clk);
          idle(C + int'($urandom_range(0, C)));
        end else begin
          idle(int'($urandom_range(0, 20)));
        end
      end
    end

    idle(LAT + 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
